// File: rtl/maze_player_ctrl.sv
// Purpose : owns the player cell and the move score inside the 15x15 maze.
// Latency : request sampled at edge N; position and score update at edge N+2.
// Backpr. : no queueing; requests that arrive while busy or after the win are dropped.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_up/i_down/i_left/i_right one-cycle move requests (priority up > down > left > right)
//   o_wall_row, o_wall_col    wall-store read address (always the player cell)
//   i_wall_bits               walls of the addressed cell, one cycle after the address
//                             {top, right, bottom, left}, 1 = wall
//   o_player_row/o_player_col current player cell
//   o_score                   successful moves, saturating at SCORE_MAX
//   o_busy                    high while a request is being evaluated
//   o_moved                   one-cycle pulse after a successful move
//   o_finished                high once the goal cell is reached
module maze_player_ctrl #(
   parameter int ROWS      = 15,
   parameter int COLS      = 15,
   parameter int START_ROW = 14,
   parameter int START_COL = 0,
   parameter int GOAL_ROW  = 0,
   parameter int GOAL_COL  = 14,
   parameter int SCORE_W   = 10,
   parameter int SCORE_MAX = 999
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_up,
   input  logic               i_down,
   input  logic               i_left,
   input  logic               i_right,
   output logic [3:0]         o_wall_row,
   output logic [3:0]         o_wall_col,
   input  logic [3:0]         i_wall_bits,
   output logic [3:0]         o_player_row,
   output logic [3:0]         o_player_col,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_busy,
   output logic               o_moved,
   output logic               o_finished
);

   localparam logic [3:0]         LAST_ROW  = 4'(ROWS - 1);
   localparam logic [3:0]         LAST_COL  = 4'(COLS - 1);
   localparam logic [3:0]         RST_ROW   = 4'(START_ROW);
   localparam logic [3:0]         RST_COL   = 4'(START_COL);
   localparam logic [3:0]         WIN_ROW   = 4'(GOAL_ROW);
   localparam logic [3:0]         WIN_COL   = 4'(GOAL_COL);
   localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

   typedef enum logic [1:0] {IDLE, WAIT, CHECK, WON} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   state_t             r_state;
   dir_t               r_dir;
   logic [3:0]         r_row;
   logic [3:0]         r_col;
   logic [SCORE_W-1:0] r_score;
   logic               r_busy;
   logic               r_moved;
   logic               r_finished;

   logic               w_blocked;
   logic [3:0]         w_step_row;
   logic [3:0]         w_step_col;
   logic [3:0]         w_dest_row;
   logic [3:0]         w_dest_col;
   logic               w_at_goal;
   logic [SCORE_W-1:0] w_score_inc;
   logic               w_any_req;

   // A move is blocked by its wall bit or by the grid edge; the edge check
   // protects against a wall store that leaves the outer border open.
   always_comb begin
      w_blocked  = 1'b1;
      w_step_row = r_row;
      w_step_col = r_col;
      case (r_dir)
         DIR_UP: begin
            w_blocked  = i_wall_bits[3] || (r_row == 4'd0);
            w_step_row = r_row - 4'd1;
         end
         DIR_DOWN: begin
            w_blocked  = i_wall_bits[1] || (r_row == LAST_ROW);
            w_step_row = r_row + 4'd1;
         end
         DIR_LEFT: begin
            w_blocked  = i_wall_bits[0] || (r_col == 4'd0);
            w_step_col = r_col - 4'd1;
         end
         DIR_RIGHT: begin
            w_blocked  = i_wall_bits[2] || (r_col == LAST_COL);
            w_step_col = r_col + 4'd1;
         end
         default: w_blocked = 1'b1;
      endcase
   end

   assign w_dest_row  = w_blocked ? r_row : w_step_row;
   assign w_dest_col  = w_blocked ? r_col : w_step_col;
   assign w_at_goal   = (w_dest_row == WIN_ROW) && (w_dest_col == WIN_COL);
   assign w_score_inc = (r_score >= SCORE_SAT) ? r_score : r_score + 1'b1;
   assign w_any_req   = i_up || i_down || i_left || i_right;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_dir      <= DIR_UP;
         r_row      <= RST_ROW;
         r_col      <= RST_COL;
         r_score    <= '0;
         r_busy     <= 1'b0;
         r_moved    <= 1'b0;
         r_finished <= 1'b0;
      end else begin
         r_moved <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  // Only the highest-priority simultaneous request survives.
                  r_dir   <= i_up   ? DIR_UP   :
                             i_down ? DIR_DOWN :
                             i_left ? DIR_LEFT : DIR_RIGHT;
                  r_busy  <= 1'b1;
                  r_state <= WAIT;
               end
            end
            // Address is already stable; this cycle covers the read latency.
            WAIT: r_state <= CHECK;
            CHECK: begin
               r_busy <= 1'b0;
               if (!w_blocked) begin
                  r_row   <= w_dest_row;
                  r_col   <= w_dest_col;
                  r_score <= w_score_inc;
                  r_moved <= 1'b1;
               end
               if (w_at_goal) begin
                  r_finished <= 1'b1;
                  r_state    <= WON;
               end else begin
                  r_state <= IDLE;
               end
            end
            WON: r_state <= WON;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read address follows the position registers so the next request sees the new cell.
   assign o_wall_row   = r_row;
   assign o_wall_col   = r_col;
   assign o_player_row = r_row;
   assign o_player_col = r_col;
   assign o_score      = r_score;
   assign o_busy       = r_busy;
   assign o_moved      = r_moved;
   assign o_finished   = r_finished;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Purpose : self-checking bench for maze_player_ctrl with a registered wall-store stub.
// Latency : compares each request's result two edges after it is sampled.
// Backpr. : exercises dropped requests while busy and after the win.
module tb_maze_player_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       up, down, left, right;
   logic [3:0] wall_row, wall_col, wall_bits, player_row, player_col;
   logic [9:0] score;
   logic       busy, moved, finished;

   int n_total = 0;
   int n_bad   = 0;

   // 0 = team maze cells, 1 = wall-free maze
   int mode = 0;

   typedef struct {
      logic [3:0] row;
      logic [3:0] col;
      logic [9:0] score;
      logic       moved;
      logic       fin;
   } exp_t;
   exp_t sb[$];

   // bench-side reference state
   logic [3:0] m_row, m_col;
   int         m_score;
   logic       m_won;

   always #5 clk = ~clk;

   maze_player_ctrl dut (
      .i_clk(clk), .i_reset(rst),
      .i_up(up), .i_down(down), .i_left(left), .i_right(right),
      .o_wall_row(wall_row), .o_wall_col(wall_col), .i_wall_bits(wall_bits),
      .o_player_row(player_row), .o_player_col(player_col),
      .o_score(score), .o_busy(busy), .o_moved(moved), .o_finished(finished)
   );

   function automatic logic [3:0] maze_cell(input logic [3:0] r, input logic [3:0] c);
      if (mode == 1) return 4'h0;
      if (r == 4'd14 && c == 4'd0) return 4'h3;
      if (r == 4'd13 && c == 4'd0) return 4'h5;
      return 4'h0;
   endfunction

   always @(posedge clk) wall_bits <= maze_cell(wall_row, wall_col);

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_row = 4'd14; m_col = 4'd0; m_score = 0; m_won = 1'b0;
   endtask

   // Predict one request from the bench's own model and push the expectation.
   task automatic predict(input logic u, input logic d, input logic l, input logic r);
      logic [3:0] w;
      logic       blk, mv;
      int         nr, nc;
      exp_t       e;
      w  = maze_cell(m_row, m_col);
      nr = m_row; nc = m_col; blk = 1'b1; mv = 1'b0;
      if (!m_won && (u || d || l || r)) begin
         if (u)      begin blk = w[3] || m_row == 0;  nr = m_row - 1; end
         else if (d) begin blk = w[1] || m_row == 14; nr = m_row + 1; end
         else if (l) begin blk = w[0] || m_col == 0;  nc = m_col - 1; end
         else        begin blk = w[2] || m_col == 14; nc = m_col + 1; end
         if (!blk) begin
            m_row = 4'(nr); m_col = 4'(nc); mv = 1'b1;
            if (m_score < 999) m_score++;
         end
         if (m_row == 4'd0 && m_col == 4'd14) m_won = 1'b1;
      end
      e.row = m_row; e.col = m_col; e.score = 10'(m_score); e.moved = mv; e.fin = m_won;
      sb.push_back(e);
   endtask

   task automatic do_move(input logic u, input logic d, input logic l, input logic r,
                          input bit extra);
      exp_t e;
      logic exp_busy;
      @(negedge clk);
      up = u; down = d; left = l; right = r;
      exp_busy = !m_won;
      predict(u, d, l, r);
      @(posedge clk);                       // edge N
      @(negedge clk);
      up = 0; down = 0; left = 0; right = 0;
      chk("busy_wait", busy, exp_busy);
      if (extra) up = 1;                    // should be dropped
      @(posedge clk);                       // edge N+1
      @(negedge clk);
      up = 0;
      chk("busy_check", busy, exp_busy);
      @(posedge clk);                       // edge N+2
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("row", player_row, e.row);
         chk("col", player_col, e.col);
         chk("score", score, e.score);
         chk("moved", moved, e.moved);
         chk("finished", finished, e.fin);
         chk("busy_done", busy, 0);
         chk("wall_row", wall_row, e.row);
         chk("wall_col", wall_col, e.col);
      end
      @(posedge clk);                       // edge N+3
      @(negedge clk);
      chk("moved_pulse_end", moved, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_row"}, player_row, 14);
      chk({tag, "_col"}, player_col, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_moved"}, moved, 0);
      chk({tag, "_fin"}, finished, 0);
      chk({tag, "_wrow"}, wall_row, 14);
      chk({tag, "_wcol"}, wall_col, 0);
   endtask

   initial begin
      up = 0; down = 0; left = 0; right = 0;
      rst = 1;
      model_reset();
      #12;
      check_reset_state("rst");
      @(negedge clk);
      rst = 0;

      // team maze
      mode = 0;
      do_move(1, 0, 0, 0, 0);   // up to (13,0)
      do_move(0, 0, 0, 1, 0);   // blocked by right wall of 0x5
      do_move(0, 1, 0, 0, 0);   // back down to (14,0)

      // wall-free stub: grid bounds and priority
      mode = 1;
      do_move(0, 1, 0, 0, 0);   // bottom edge
      do_move(0, 0, 1, 0, 0);   // left edge
      do_move(1, 0, 0, 1, 0);   // up wins over right
      do_move(0, 1, 0, 0, 1);   // extra up while busy is dropped

      // reset while in CHECK
      @(negedge clk);
      up = 1;
      @(posedge clk);
      @(negedge clk);
      up = 0;
      @(posedge clk);           // now in CHECK
      #2 rst = 1;
      #1 check_reset_state("rst_check");
      model_reset();
      @(negedge clk);
      rst = 0;

      // walk to the goal
      for (int i = 0; i < 14; i++) do_move(1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) do_move(0, 0, 0, 1, 0);
      chk("goal_fin", finished, 1);
      chk("goal_row", player_row, 0);
      chk("goal_col", player_col, 14);
      chk("goal_score", score, 28);
      do_move(0, 1, 0, 0, 0);   // frozen after the win
      do_move(0, 0, 1, 0, 0);

      // score saturation
      @(negedge clk);
      rst = 1;
      model_reset();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) do_move(1, 0, 0, 0, 0);
         else            do_move(0, 1, 0, 0, 0);
      end
      chk("sat_score", score, 999);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Upstream stage of the maze renderer: owns the player's cell position in the 15x15 maze and the move score.
- Accepts single-cycle direction pulses (already debounced and edge-detected).
- Queries a wall store for the current cell's walls and moves the player only when no wall blocks the move.
- Outputs the player cell, score and finish status, which the renderer consumes to draw the player and the end-of-game state.

Parameters:
- ROWS, 15, number of maze rows; row 0 is the top.
- COLS, 15, number of maze columns; col 0 is the left.
- START_ROW, 14, reset row (bottom-left start cell).
- START_COL, 0, reset column.
- GOAL_ROW, 0, finish row (top-right finish cell).
- GOAL_COL, 14, finish column.
- SCORE_W, 10, score register width.
- SCORE_MAX, 999, score saturation value.

Ports:
- clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Up  input  1  one-cycle move request, direction up (row-1).
- Down  input  1  one-cycle move request, direction down (row+1).
- Left  input  1  one-cycle move request, direction left (col-1).
- Right  input  1  one-cycle move request, direction right (col+1).
- wall_row  output  4  wall-store read row; always equals player_row.
- wall_col  output  4  wall-store read column; always equals player_col.
- wall_bits  input  4  walls of cell (wall_row, wall_col), valid 1 cycle after the address. Bit3 = top, bit2 = right, bit1 = bottom, bit0 = left; 1 = wall.
- player_row  output  4  current player row.
- player_col  output  4  current player column.
- score  output  SCORE_W  count of successful moves.
- busy  output  1  high while a request is being evaluated.
- moved  output  1  one-cycle pulse when the position changes.
- finished  output  1  high once the goal cell is reached.

Behaviour:
- Reset (asynchronous, any state, mid-evaluation included) sets:
  - player_row = START_ROW, player_col = START_COL
  - score = 0, busy = 0, moved = 0, finished = 0
  - state = IDLE, latched direction cleared.
- FSM states: IDLE, WAIT, CHECK, WON.
- IDLE:
  - If any direction input is high at a clk edge, latch one direction and go to WAIT. Priority is Up > Down > Left > Right; the other simultaneous pulses are dropped.
  - With no input, stay in IDLE.
- WAIT: one cycle to cover the wall-store read latency; busy = 1. Next state is CHECK.
- CHECK (busy = 1): evaluate wall_bits against the latched direction. A move is blocked if either:
  - the matching wall bit is 1, or
  - the move would leave the grid: Up at row 0, Down at row ROWS-1, Left at col 0, Right at col COLS-1. The grid bound is enforced even if wall_bits reports no wall.
- If not blocked, at the CHECK edge:
  - update the position;
  - score = score + 1, saturating at SCORE_MAX;
  - moved pulses for exactly the following cycle.
- If blocked: position, score and moved are unchanged.
- Next state after CHECK is WON if the new position equals (GOAL_ROW, GOAL_COL), else IDLE.
- Latency: request sampled at edge N; position and score change at edge N+2; moved is high from N+2 to N+3.
- Requests arriving while busy (WAIT or CHECK) are ignored; they are not queued.
- WON: finished = 1. All direction inputs are ignored and the position and score are frozen until Reset.
- wall_row and wall_col track the player position registers, so after a move the next request reads the new cell.

Test Plan:
- Reset, then check outputs: player = (14,0), score = 0, finished = 0, busy = 0, wall_row/col = 14/0.
- Stub the wall store as the team maze (cell (14,0) = 0x3, (13,0) = 0x5). Pulse Up -> two edges later player = (13,0), score = 1, moved high for one cycle.
- From (13,0), pulse Right -> blocked by bit2 of 0x5: player stays (13,0), score stays 1, moved stays 0.
- At (14,0) with the stub forced to 0x0, pulse Down or Left -> blocked by the grid bound, no change. Pulse Up and Right in the same cycle -> only Up is taken, giving (13,0).
- Pulse Up during busy -> ignored. Assert Reset during CHECK -> immediately (14,0), score 0, state IDLE.
- Drive a wall-free stub and walk Up 14 and Right 14 -> finished = 1, player = (0,14), score = 28. A further pulse changes nothing. Separately, 1000 legal moves leave score saturated at 999.
